// File: rtl/dsp_and_result_checker_pkg.sv
// ----------------------------------------------------------------------------
// dsp_and_result_checker_pkg
// Shared definitions for the DSP AND result checker:
//   - chk_state_e : checker FSM states
//   - NO_ERR_IDX  : first_err_idx value meaning "no mismatch seen"
//   - sat_inc16   : saturating 16-bit increment used by the error counter
// ----------------------------------------------------------------------------
package dsp_and_result_checker_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } chk_state_e;

    localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/chk_delay_line.sv
// ----------------------------------------------------------------------------
// chk_delay_line
// LATENCY-deep shift line carrying {valid, expected} alongside the DSP AND
// pipeline, so each expected value reaches the output in the same cycle as
// the matching DSP result.
// Ports:
//   i_clock : clock, rising edge
//   i_reset : asynchronous active-high reset, clears every stage (all invalid)
//   i_data  : entry pushed every cycle
//   o_data  : oldest entry (pushed LATENCY edges ago)
// ----------------------------------------------------------------------------
module chk_delay_line
    import dsp_and_result_checker_pkg::*;
#(
    parameter int unsigned WIDTH   = 9,
    parameter int unsigned LATENCY = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [LATENCY];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[LATENCY-1];

endmodule

// File: rtl/dsp_and_result_checker.sv
// ----------------------------------------------------------------------------
// dsp_and_result_checker
// Checks the output of an external pipelined DSP AND against a & b.
// A run is started with a one-cycle start pulse; count vectors are issued
// (in_valid), their expected results travel down a shift line matching the
// DSP latency, and each arriving result is compared against y.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   start, count        : begin a run of count vectors (count sampled on start)
//   in_valid, a, b      : operand pair issued to the DSP AND this cycle
//   y                   : DSP AND result, LATENCY cycles after issue
//   busy                : high in RUN or DRAIN
//   done, pass          : run finished; pass = no mismatches
//   err_count           : saturating mismatch count
//   first_err_idx       : index of first mismatching vector, FFFF if none
// ----------------------------------------------------------------------------
module dsp_and_result_checker
    import dsp_and_result_checker_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      count,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    chk_state_e  r_state, w_state_d;
    logic [15:0] r_count, w_count_d;
    logic [15:0] r_issued, w_issued_d;
    logic [15:0] r_checked, w_checked_d;
    logic [15:0] r_err_count, w_err_count_d;
    logic [15:0] r_first_err_idx, w_first_err_idx_d;
    logic        r_busy, r_done, r_pass;

    logic             w_active;
    logic             w_push_valid;
    logic [WIDTH:0]   w_push;
    logic [WIDTH:0]   w_line_out;
    logic             w_chk_valid;
    logic [WIDTH-1:0] w_exp;
    logic             w_mismatch;

    // Only RUN issues vectors; every other state pushes invalid entries.
    assign w_active     = (r_state == StRun) || (r_state == StDrain);
    assign w_push_valid = (r_state == StRun) && in_valid;
    assign w_push       = {w_push_valid, w_push_valid ? (a & b) : {WIDTH{1'b0}}};

    chk_delay_line #(
        .WIDTH   (WIDTH + 1),
        .LATENCY (LATENCY)
    ) u_delay_line (
        .i_clock (clock),
        .i_reset (reset),
        .i_data  (w_push),
        .o_data  (w_line_out)
    );

    assign w_exp       = w_line_out[WIDTH-1:0];
    assign w_chk_valid = w_line_out[WIDTH] && w_active;
    assign w_mismatch  = w_chk_valid && (y != w_exp);

    always_comb begin
        w_state_d         = r_state;
        w_count_d         = r_count;
        w_issued_d        = r_issued;
        w_checked_d       = r_checked;
        w_err_count_d     = r_err_count;
        w_first_err_idx_d = r_first_err_idx;

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_count_d         = count;
                    w_issued_d        = 16'd0;
                    w_checked_d       = 16'd0;
                    w_err_count_d     = 16'd0;
                    w_first_err_idx_d = NO_ERR_IDX;
                    w_state_d         = (count == 16'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (in_valid) begin
                    w_issued_d = r_issued + 16'd1;
                end
                if (w_issued_d == r_count) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Check path runs in parallel with issue; reaching count wins over DRAIN.
        if (w_chk_valid) begin
            w_checked_d = r_checked + 16'd1;
            if (w_mismatch) begin
                w_err_count_d = sat_inc16(r_err_count);
                if (r_err_count == 16'd0) begin
                    w_first_err_idx_d = r_checked;
                end
            end
            if (w_checked_d == r_count) begin
                w_state_d = StDone;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= StIdle;
            r_count         <= 16'd0;
            r_issued        <= 16'd0;
            r_checked       <= 16'd0;
            r_err_count     <= 16'd0;
            r_first_err_idx <= NO_ERR_IDX;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_count         <= w_count_d;
            r_issued        <= w_issued_d;
            r_checked       <= w_checked_d;
            r_err_count     <= w_err_count_d;
            r_first_err_idx <= w_first_err_idx_d;
            // Status flags are registered from the next state so they line up with it.
            r_busy          <= (w_state_d == StRun) || (w_state_d == StDrain);
            r_done          <= (w_state_d == StDone);
            r_pass          <= (w_state_d == StDone) && (w_err_count_d == 16'd0);
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule
